// File: rtl/qmult_rr_scheduler.sv
// Round-robin scheduler that time-shares one signed-magnitude fixed-point
// multiplier among NREQ requesters, with one operation in flight at a time.

module qmult #(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         ovr
);
  logic [2*N-3:0] mag;

  // Magnitude product keeps all 2N-2 bits; the window [N-2+Q:Q] is the result,
  // anything above it is overflow. Low bits are truncated, never rounded.
  always_comb begin
    mag    = (2*N-2)'(a[N-2:0]) * (2*N-2)'(b[N-2:0]);
    result = {a[N-1] ^ b[N-1], (N-1)'(mag >> Q)};
    ovr    = (mag >> (N - 1 + Q)) != '0;
  end
endmodule

module qmult_rr_scheduler #(
  parameter int N    = 16,
  parameter int Q    = 12,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*N-1:0] i_multiplicand,
  input  logic [NREQ*N-1:0] i_multiplier,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [N-1:0]      o_result,
  output logic              o_ovr,
  output logic [IDW-1:0]    o_res_id,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gidx;
  logic            found;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    mul_res;
  logic            mul_ovr;

  qmult #(.N(N), .Q(Q)) u_mul (
    .a      (op_a),
    .b      (op_b),
    .result (mul_res),
    .ovr    (mul_ovr)
  );

  // Scan from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(last) + i) % NREQ);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      o_req_ready[k] = found && (state == IDLE) && !i_rst && (gidx == IDW'(k));
    end
  end

  assign o_busy = (state != IDLE);

  // o_res_id is only updated together with o_result so it always names the
  // owner of the value currently on o_result, even after the handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last        <= IDW'(NREQ - 1);
      id          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      o_res_valid <= 1'b0;
      o_result    <= '0;
      o_ovr       <= 1'b0;
      o_res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a  <= i_multiplicand[32'(gidx)*N +: N];
            op_b  <= i_multiplier[32'(gidx)*N +: N];
            id    <= gidx;
            last  <= gidx;
            state <= MUL;
          end
        end
        MUL: begin
          o_result    <= mul_res;
          o_ovr       <= mul_ovr;
          o_res_id    <= id;
          o_res_valid <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qmult_rr_scheduler.sv
// Bench for qmult_rr_scheduler: directed and randomized operations checked
// against an arithmetic model of the multiply and a rotating-priority model.

module tb_qmult_rr_scheduler;
  localparam int N    = 16;
  localparam int Q    = 12;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] mcand;
  logic [NREQ*N-1:0] mplier;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [N-1:0]      result;
  logic              ovr;
  logic [IDW-1:0]    res_id;
  logic              busy;

  logic [N-1:0] va [NREQ];
  logic [N-1:0] vb [NREQ];

  int tests  = 0;
  int fails  = 0;
  int last_m = NREQ - 1;

  qmult_rr_scheduler #(.N(N), .Q(Q), .NREQ(NREQ), .IDW(IDW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_result       (result),
    .o_ovr          (ovr),
    .o_res_id       (res_id),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      mcand[k*N +: N]  = va[k];
      mplier[k*N +: N] = vb[k];
    end
  end

  // Returns {ovr, result} from plain integer arithmetic on the magnitudes.
  function automatic logic [N:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ma, mb, mag, rmag;
    logic sgn;
    logic ov;
    ma   = longint'(a) % (64'd1 << (N-1));
    mb   = longint'(b) % (64'd1 << (N-1));
    mag  = ma * mb;
    rmag = (mag / (64'd1 << Q)) % (64'd1 << (N-1));
    ov   = mag >= (64'd1 << (N - 1 + Q));
    sgn  = a[N-1] ^ b[N-1];
    return {ov, sgn, (N-1)'(rmag)};
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
    for (int s = 1; s <= NREQ; s++) begin
      if (v[(last + s) % NREQ]) return (last + s) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rv"},   32'(res_valid), 32'd0);
    check({tag, "_res"},  32'(result),    32'd0);
    check({tag, "_ovr"},  32'(ovr),       32'd0);
    check({tag, "_id"},   32'(res_id),    32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst    = 1'b0;
    last_m = NREQ - 1;
  endtask

  // Called at a negedge with the DUT idle and requests already driven.
  // rst_at: 0 none, 1 pulse reset during MUL, 2 pulse reset during RESP.
  task automatic serve(input int bp, input bit refill, input int rst_at);
    int g;
    logic [N:0] e;
    #1;
    g = model_grant(req_valid, last_m);
    if (g < 0) begin
      check("ready_none", 32'(req_ready), 32'd0);
      check("busy_none", 32'(busy), 32'd0);
      @(negedge clk);
      return;
    end
    check("grant", 32'(req_ready), 32'd1 << g);
    @(posedge clk);
    last_m = g;
    e = model_mul(va[g], vb[g]);
    @(negedge clk);
    if (refill) begin
      va[g] = N'($urandom);
      vb[g] = N'($urandom);
    end else begin
      req_valid[g] = 1'b0;
    end
    check("mul_busy", 32'(busy), 32'd1);
    check("mul_ready", 32'(req_ready), 32'd0);
    check("mul_rv", 32'(res_valid), 32'd0);
    if (rst_at == 1) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("rst_mul");
      last_m = NREQ - 1;
      return;
    end
    res_ready = (bp == 0);
    @(negedge clk);
    check("resp_rv", 32'(res_valid), 32'd1);
    check("resp_res", 32'(result), 32'(e[N-1:0]));
    check("resp_ovr", 32'(ovr), 32'(e[N]));
    check("resp_id", 32'(res_id), 32'(g));
    check("resp_busy", 32'(busy), 32'd1);
    check("resp_ready", 32'(req_ready), 32'd0);
    if (rst_at == 2) begin
      rst       = 1'b1;
      res_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("rst_resp");
      last_m    = NREQ - 1;
      res_ready = 1'b1;
      return;
    end
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      check("hold_rv", 32'(res_valid), 32'd1);
      check("hold_res", 32'(result), 32'(e[N-1:0]));
      check("hold_id", 32'(res_id), 32'(g));
      check("hold_ready", 32'(req_ready), 32'd0);
      if (j == bp - 1) res_ready = 1'b1;
    end
    @(negedge clk);
    check("done_rv", 32'(res_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_res", 32'(result), 32'(e[N-1:0]));
    check("done_id", 32'(res_id), 32'(g));
  endtask

  logic [N-1:0] dir_a   [5] = '{16'h1800, 16'h9800, 16'h8000, 16'h0001, 16'h7000};
  logic [N-1:0] dir_b   [5] = '{16'h2000, 16'h2000, 16'h1000, 16'h0001, 16'h2000};
  logic [N-1:0] dir_res [5] = '{16'h3000, 16'hB000, 16'h8000, 16'h0000, 16'h6000};
  logic         dir_ovr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      va[k] = '0;
      vb[k] = '0;
    end
    @(negedge clk);
    do_reset();

    // Directed arithmetic cases, each from requester 0 alone.
    for (int i = 0; i < 5; i++) begin
      va[0]     = dir_a[i];
      vb[0]     = dir_b[i];
      req_valid = 4'b0001;
      serve(0, 1'b0, 0);
      check("dir_result", 32'(result), 32'(dir_res[i]));
      check("dir_ovr", 32'(ovr), 32'(dir_ovr[i]));
    end

    // Fairness: all valid from reset, grants rotate 0,1,2,3,0,1.
    for (int k = 0; k < NREQ; k++) begin
      va[k] = N'($urandom);
      vb[k] = N'($urandom);
    end
    req_valid = '1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("rr_order_model", 32'(model_grant(req_valid, last_m)), 32'(i % NREQ));
      serve(0, 1'b1, 0);
    end

    // Backpressure with requesters 1 and 2 pending.
    req_valid = 4'b0110;
    serve(5, 1'b0, 0);
    serve(0, 1'b0, 0);

    // Reset in MUL, then in RESP; requester 0 must win afterwards.
    req_valid = '1;
    serve(0, 1'b1, 1);
    serve(0, 1'b1, 0);
    serve(0, 1'b1, 2);
    serve(0, 1'b1, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k]) begin
          va[k] = N'($urandom);
          vb[k] = N'($urandom);
        end
      end
      req_valid = NREQ'($urandom_range(0, 15));
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
